slow_mem_model: RTL and testbench



---
 rtl/slow_mem_pkg.sv | 15 +
 rtl/slow_mem_model.sv | 115 +++++++++++
 tb/tb_slow_mem_model.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/slow_mem_pkg.sv
// Shared types and default constants for the slow main-memory model.
package slow_mem_pkg;

    localparam int unsigned LINE_W      = 128;
    localparam int unsigned DEF_LATENCY = 5;
    localparam int unsigned DEF_MEM_NUM = 256;
    localparam int unsigned DEF_ADDR_W  = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_e;

endpackage

// File: rtl/slow_mem_model.sv
// Cycle-accurate off-chip memory: 128-bit line reads/writes with a fixed latency.
// Define SLOW_MEM_PROTO_CHECK_EN to enable simulation-only handshake protocol checks.
module slow_mem_model
    import slow_mem_pkg::*;
#(
    parameter int unsigned MEM_NUM = DEF_MEM_NUM,
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready
);

    localparam int unsigned IDX_W = $clog2(MEM_NUM);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    // Storage is never reset; benches preload it hierarchically.
    logic [LINE_W-1:0] mem [0:MEM_NUM-1];

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_write_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] wdata_q;

    logic [IDX_W-1:0]  idx_c;
    logic              req_c;

    assign idx_c = mem_addr[IDX_W-1:0];
    assign req_c = mem_read | mem_write;

    generate
        if (ADDR_W > IDX_W) begin : g_upper
            // Upper address bits only wrap the index.
            logic unused_upper_c;
            assign unused_upper_c = ^mem_addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            mem_ready  <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            mem_ready <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_c) begin
                        state_q    <= WAIT;
                        is_write_q <= mem_write;
                        idx_q      <= idx_c;
                        wdata_q    <= mem_wdata;
                        cnt_q      <= CNT_W'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (!req_c) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q   <= READY;
                        mem_ready <= 1'b1;
                        if (!is_write_q) begin
                            mem_rdata <= mem[idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                READY: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Write commits at the edge leaving READY; a reset beforehand discards it.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == READY && is_write_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef SLOW_MEM_PROTO_CHECK_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (mem_read && mem_write)
                $display("%0t slow_mem_model error: mem_read and mem_write both high", $time);
            if (state_q == WAIT && req_c && mem_addr[IDX_W-1:0] != idx_q)
                $display("%0t slow_mem_model error: mem_addr changed during WAIT", $time);
            if (state_q == WAIT && req_c && is_write_q && mem_wdata != wdata_q)
                $display("%0t slow_mem_model error: mem_wdata changed during WAIT", $time);
            if (state_q == WAIT && !req_c)
                $display("%0t slow_mem_model error: request dropped before ready", $time);
            if (req_c && mem_addr >= ADDR_W'(MEM_NUM))
                $display("%0t slow_mem_model error: address index out of range", $time);
        end
    end
`endif

endmodule

// File: tb/tb_slow_mem_model.sv
// Directed self-checking bench for slow_mem_model (default parameters).
module tb_slow_mem_model;
    import slow_mem_pkg::*;

    localparam logic [LINE_W-1:0] P3  = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0003;
    localparam logic [LINE_W-1:0] P5  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    localparam logic [LINE_W-1:0] P10 = 128'hA0A0_A0A0_A0A0_A0A0_A0A0_A0A0_A0A0_A0A0;
    localparam logic [LINE_W-1:0] P20 = 128'h2020_0000_1111_2222_3333_4444_5555_0020;
    localparam logic [LINE_W-1:0] W10 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [LINE_W-1:0] W7  = 128'h7777_0000_7777_0000_7777_0000_7777_0007;
    localparam logic [LINE_W-1:0] W5  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    localparam logic [LINE_W-1:0] D12 = 128'hC0DE_0012_C0DE_0012_C0DE_0012_C0DE_0012;
    localparam logic [LINE_W-1:0] W3  = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0003;
    localparam int                EXP_LAT = DEF_LATENCY + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_read;
    logic              mem_write;
    logic [27:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    int n_checks = 0;
    int n_errs   = 0;
    int lat;
    int seen;

    slow_mem_model dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a request until ready (bounded); lat counts edges from assertion to the ready sample.
    task automatic do_req(input logic rd, input logic wr, input logic [27:0] a,
                          input logic [LINE_W-1:0] wd, output int n);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = wd;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_ready && n < 20);
    endtask

    task automatic end_req(input string tag);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
        check(tag, 128'(mem_ready), 128'(0));
    endtask

    task automatic count_ready(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (mem_ready) cnt++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        dut.mem[3]  = P3;
        dut.mem[5]  = P5;
        dut.mem[10] = P10;
        dut.mem[20] = P20;

        tick();
        tick();
        check("rst_ready", 128'(mem_ready), 128'(0));
        check("rst_rdata", mem_rdata, '0);
        rst_n = 1'b1;
        tick();

        // Read latency and single-cycle pulse; held request must not retrigger.
        do_req(1'b1, 1'b0, 28'd3, '0, lat);
        check("rd3_lat", 128'(lat), 128'(EXP_LAT));
        check("rd3_data", mem_rdata, P3);
        tick();
        check("rd3_pulse", 128'(mem_ready), 128'(0));
        mem_read = 1'b0;
        count_ready(8, seen);
        check("rd3_no_retrigger", 128'(seen), 128'(0));

        // Write then read back; old value kept through the ready cycle.
        do_req(1'b0, 1'b1, 28'd10, W10, lat);
        check("wr10_lat", 128'(lat), 128'(EXP_LAT));
        check("wr10_old_kept", dut.mem[10], P10);
        end_req("wr10_pulse");
        check("wr10_committed", dut.mem[10], W10);
        check("wr10_rdata_hold", mem_rdata, P3);
        do_req(1'b1, 1'b0, 28'd10, '0, lat);
        check("rd10_data", mem_rdata, W10);
        end_req("rd10_pulse");

        // Address wrap modulo MEM_NUM.
        do_req(1'b0, 1'b1, 28'h107, W7, lat);
        check("wrap_lat", 128'(lat), 128'(EXP_LAT));
        end_req("wrap_pulse");
        check("wrap_mem7", dut.mem[7], W7);
        do_req(1'b1, 1'b0, 28'd7, '0, lat);
        check("wrap_rd7", mem_rdata, W7);
        end_req("wrap_rd_pulse");

        // Abort: write dropped after two cycles.
        mem_write = 1'b1;
        mem_addr  = 28'd5;
        mem_wdata = W5;
        tick();
        tick();
        mem_write = 1'b0;
        count_ready(10, seen);
        check("abort_no_ready", 128'(seen), 128'(0));
        check("abort_mem5", dut.mem[5], P5);
        do_req(1'b1, 1'b0, 28'd5, '0, lat);
        check("abort_next_lat", 128'(lat), 128'(EXP_LAT));
        check("abort_next_data", mem_rdata, P5);
        end_req("abort_next_pulse");

        // Read and write together act as a write.
        do_req(1'b1, 1'b1, 28'd12, D12, lat);
        check("both_lat", 128'(lat), 128'(EXP_LAT));
        check("both_rdata_hold", mem_rdata, P5);
        end_req("both_pulse");
        check("both_mem12", dut.mem[12], D12);

        // Back-to-back: drop at ready edge, reassert right after.
        do_req(1'b1, 1'b0, 28'd3, '0, lat);
        check("b2b_first_data", mem_rdata, P3);
        end_req("b2b_gap");
        do_req(1'b1, 1'b0, 28'd10, '0, lat);
        check("b2b_second_lat", 128'(lat), 128'(EXP_LAT));
        check("b2b_second_data", mem_rdata, W10);
        end_req("b2b_second_pulse");

        // Reset mid-WAIT discards a pending write.
        mem_write = 1'b1;
        mem_addr  = 28'd3;
        mem_wdata = W3;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rstw_ready", 128'(mem_ready), 128'(0));
        check("rstw_rdata", mem_rdata, '0);
        mem_write = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rstw_mem3", dut.mem[3], P3);
        do_req(1'b1, 1'b0, 28'd3, '0, lat);
        check("rstw_rd_lat", 128'(lat), 128'(EXP_LAT));
        check("rstw_rd_data", mem_rdata, P3);
        end_req("rstw_rd_pulse");

        // Reset while ready is high drops outputs immediately.
        do_req(1'b1, 1'b0, 28'd20, '0, lat);
        check("rstr_data", mem_rdata, P20);
        #2 rst_n = 1'b0;
        #1;
        check("rstr_ready", 128'(mem_ready), 128'(0));
        check("rstr_rdata", mem_rdata, '0);
        mem_read = 1'b0;
        tick();
        rst_n = 1'b1;
        count_ready(4, seen);
        check("rstr_quiet", 128'(seen), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
